// File: rtl/correlator_core.sv
// rtl/correlator_core.sv - delay-line pulse correlator: per-input auto counts and per-pair lagged
// coincidence counts, integrated over a programmable window and streamed out frame by frame.
module correlator_core #(
  parameter int NUM_INPUTS = 8,
  parameter int RESOLUTION = 16,
  parameter int MAX_DELAY  = 64,
  parameter int MAX_LAG    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] pulse_in,
  input  logic                  cfg_we,
  input  logic [7:0]            cfg_addr,
  input  logic [31:0]           cfg_data,
  output logic [RESOLUTION-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overrun,
  output logic                  saturated
);

  localparam int NL = 2 * MAX_LAG + 1;
  localparam int NP = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
  localparam int NC = NUM_INPUTS + NP * NL;
  localparam int F  = 1 + NC;
  localparam int DW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int TW = (MAX_LAG > 0) ? 2 * MAX_LAG : 1;
  localparam int IW = $clog2(F + 1);
  localparam logic [RESOLUTION-1:0] SAT      = '1;
  localparam logic [IW-1:0]         LAST_IDX = IW'(F - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [NUM_INPUTS-1:0] x;
  logic [MAX_DELAY-1:0]  hist [NUM_INPUTS];
  logic [DW-1:0]         delay [NUM_INPUTS];
  logic [TW-1:0]         taps [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] d;
  logic [NL-1:0]         dl [NUM_INPUTS];
  logic [NC-1:0]         inc;
  logic [RESOLUTION-1:0] cnt [NC];
  logic [RESOLUTION-1:0] cnt_nx [NC];
  logic [RESOLUTION-1:0] bank [NC];
  logic [RESOLUTION-1:0] seq, snap_seq;
  logic [31:0]           int_len, win;
  logic                  any_sat, win_last, accept_last, take;
  state_t                state, state_nx;
  logic [IW-1:0]         idx, idx_nx;

  // dl[i][k] is d_i(t-k); the pair term uses k = L for side a and k = L+l for side b
  always_comb begin
    int j;
    j = NUM_INPUTS;
    inc = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      d[i] = (delay[i] == '0) ? x[i] : hist[i][delay[i] - 1'b1];
      dl[i] = '0;
      dl[i][0] = d[i];
      for (int k = 1; k < NL; k++) dl[i][k] = taps[i][k-1];
      inc[i] = d[i];
    end
    for (int a = 0; a < NUM_INPUTS; a++)
      for (int b = a + 1; b < NUM_INPUTS; b++)
        for (int k = 0; k < NL; k++) begin
          inc[j] = dl[a][MAX_LAG] & dl[b][k];
          j++;
        end
  end

  always_comb begin
    any_sat = 1'b0;
    for (int j = 0; j < NC; j++) begin
      cnt_nx[j] = (cnt[j] == SAT) ? SAT : cnt[j] + {{(RESOLUTION-1){1'b0}}, inc[j]};
      any_sat = any_sat | (cnt_nx[j] == SAT);
    end
  end

  assign win_last    = (int_len != 32'd0) && (win == int_len - 32'd1);
  assign accept_last = (state == S_SEND) && out_ready && (idx == LAST_IDX);
  assign take        = win_last && ((state == S_IDLE) || accept_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      int_len <= '0;
      win <= '0;
      seq <= '0;
      snap_seq <= '0;
      overrun <= 1'b0;
      saturated <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        hist[i] <= '0;
        taps[i] <= '0;
        delay[i] <= '0;
      end
      for (int j = 0; j < NC; j++) begin
        cnt[j] <= '0;
        bank[j] <= '0;
      end
    end else begin
      x <= pulse_in;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        hist[i] <= MAX_DELAY'({hist[i], x[i]});
        taps[i] <= TW'({taps[i], d[i]});
        if (cfg_we && cfg_addr == 8'(i))
          delay[i] <= (cfg_data >= 32'(MAX_DELAY)) ? DW'(MAX_DELAY - 1) : cfg_data[DW-1:0];
      end
      if (cfg_we && cfg_addr == 8'd255) begin
        int_len <= cfg_data;
        win <= '0;
        seq <= '0;
        for (int j = 0; j < NC; j++) cnt[j] <= '0;
      end else if (int_len != 32'd0) begin
        saturated <= saturated | any_sat;
        if (win_last) begin
          win <= '0;
          seq <= seq + 1'b1;
          for (int j = 0; j < NC; j++) cnt[j] <= '0;
          // a busy readout keeps the bank intact; only the sequence gap reveals the loss
          if (take) begin
            snap_seq <= seq;
            for (int j = 0; j < NC; j++) bank[j] <= cnt_nx[j];
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          win <= win + 32'd1;
          for (int j = 0; j < NC; j++) cnt[j] <= cnt_nx[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx = idx;
    case (state)
      S_IDLE: if (take) begin
        state_nx = S_SEND;
        idx_nx = '0;
      end
      S_SEND: if (out_ready) begin
        if (idx == LAST_IDX) begin
          state_nx = take ? S_SEND : S_IDLE;
          idx_nx = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == S_SEND);
    out_last = out_valid && (idx == LAST_IDX);
    out_data = '0;
    if (out_valid) begin
      if (idx == '0) out_data = snap_seq;
      for (int j = 0; j < NC; j++)
        if (idx == IW'(j + 1)) out_data = bank[j];
    end
  end

endmodule

// File: tb/tb_correlator_core.sv
// tb/tb_correlator_core.sv - directed self-checking bench for correlator_core (N=4, 16 bit, depth 8, L=2).
module tb_correlator_core;

  localparam int N = 4;
  localparam int F = 35;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  pulse_in;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        overrun;
  logic        saturated;

  int checks = 0;
  int failures = 0;

  bit         gen_mode = 1'b0;
  logic [3:0] gen_static = '0;
  logic [3:0] gen_mask = '0;
  int         gen_cnt = 0;

  logic [15:0] w [F];
  logic        lst [F];
  bit          stable_ok;

  correlator_core #(
    .NUM_INPUTS(N), .RESOLUTION(16), .MAX_DELAY(8), .MAX_LAG(2)
  ) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .overrun(overrun), .saturated(saturated)
  );

  initial forever #5 clk = ~clk;

  // static level, or a single pulse on the masked inputs every 10 clocks
  initial begin
    pulse_in = '0;
    forever begin
      @(negedge clk);
      gen_cnt++;
      pulse_in = gen_mode ? ((gen_cnt % 10 == 0) ? gen_mask : 4'b0000) : gen_static;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b0;
    cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = v;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int c = 0;
    while (!out_valid && c < bound) begin
      @(negedge clk);
      c++;
    end
    check(tag, {31'b0, out_valid}, 32'd1);
  endtask

  // called at a negedge; words accepted on the following posedge are recorded
  task automatic read_frame(input int stall_at, input int stall_len);
    int n = 0;
    int cyc = 0;
    int stall = 0;
    logic [15:0] hd = '0;
    logic hl = 1'b0;
    stable_ok = 1'b1;
    while (n < F && cyc < 3000) begin
      if (n == stall_at && out_valid && stall < stall_len) begin
        out_ready = 1'b0;
        if (stall == 0) begin
          hd = out_data;
          hl = out_last;
        end else if (out_data !== hd || out_last !== hl || out_valid !== 1'b1) begin
          stable_ok = 1'b0;
        end
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        w[n] = out_data;
        lst[n] = out_last;
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("frame_words", n, F);
  endtask

  function automatic int sum_words(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(w[i]);
    return s;
  endfunction

  initial begin
    int nlast;
    int at_last;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_last", {31'b0, out_last}, 0);
    check("rst_data", {16'b0, out_data}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    check("rst_saturated", {31'b0, saturated}, 0);

    // basic counts and valid latency
    gen_mode = 1'b0;
    gen_static = 4'b0001;
    do_reset();
    repeat (5) @(negedge clk);
    cfg_write(8'd255, 32'd100);
    repeat (99) @(posedge clk);
    #1 check("basic_valid_early", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1 check("basic_valid_rise", {31'b0, out_valid}, 1);
    @(negedge clk);
    read_frame(-1, 0);
    check("basic_seq", {16'b0, w[0]}, 0);
    check("basic_a0", {16'b0, w[1]}, 100);
    check("basic_a123", sum_words(2, 4), 0);
    check("basic_cross", sum_words(5, F - 1), 0);
    nlast = 0;
    at_last = -1;
    for (int i = 0; i < F; i++) if (lst[i]) begin nlast++; at_last = i; end
    check("basic_last_count", nlast, 1);
    check("basic_last_pos", at_last, F - 1);

    // reset mid-frame, then seq restarts at 0
    do_reset();
    cfg_write(8'd255, 32'd20);
    wait_valid("midrst_wait", 60);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 check("midrst_valid", {31'b0, out_valid}, 0);
    @(negedge clk);
    reset = 1'b0;
    cfg_write(8'd255, 32'd20);
    wait_valid("midrst_wait2", 60);
    read_frame(-1, 0);
    check("midrst_seq", {16'b0, w[0]}, 0);
    check("midrst_a0", {16'b0, w[1]}, 20);

    // programmed lag: delay_1 = 3 pushes the coincidence to lag -3, outside the window
    gen_mode = 1'b1;
    gen_mask = 4'b0011;
    do_reset();
    cfg_write(8'd1, 32'd3);
    repeat (20) @(negedge clk);
    cfg_write(8'd255, 32'd50);
    wait_valid("lag3_wait", 80);
    read_frame(-1, 0);
    check("lag3_a0", {16'b0, w[1]}, 5);
    check("lag3_a1", {16'b0, w[2]}, 5);
    check("lag3_pair01", sum_words(5, 9), 0);

    // delay_1 = 1: coincidence at lag -1 (word 6)
    do_reset();
    cfg_write(8'd1, 32'd1);
    repeat (20) @(negedge clk);
    cfg_write(8'd255, 32'd50);
    wait_valid("lag1_wait", 80);
    read_frame(-1, 0);
    check("lag1_word", {16'b0, w[6]}, 5);
    check("lag1_pair01", sum_words(5, 9), 5);

    // delay_0 = 100 clamps to 7, delay_1 = 5: lag +2 (word 9)
    do_reset();
    cfg_write(8'd0, 32'd100);
    cfg_write(8'd1, 32'd5);
    repeat (20) @(negedge clk);
    cfg_write(8'd255, 32'd50);
    wait_valid("clamp_wait", 80);
    read_frame(-1, 0);
    check("clamp_word", {16'b0, w[9]}, 5);
    check("clamp_pair01", sum_words(5, 9), 5);

    // back-pressure: all inputs pulse together, 20-clock stall at word 10
    gen_mask = 4'b1111;
    do_reset();
    repeat (20) @(negedge clk);
    cfg_write(8'd255, 32'd100);
    wait_valid("bp_wait", 140);
    read_frame(10, 20);
    check("bp_stable", {31'b0, stable_ok}, 1);
    for (int i = 0; i < F; i++) begin
      int exp_w;
      if (i == 0) exp_w = 0;
      else if (i <= N) exp_w = 10;
      else exp_w = (((i - 5) % 5) == 2) ? 10 : 0;
      check($sformatf("bp_word%0d", i), {16'b0, w[i]}, exp_w);
    end

    // overrun: frames held with out_ready low, windows of 10 clocks keep ending
    gen_mode = 1'b0;
    gen_static = 4'b0000;
    do_reset();
    cfg_write(8'd255, 32'd10);
    repeat (15) @(posedge clk);
    #1 check("ovr_early", {31'b0, overrun}, 0);
    check("ovr_held_valid", {31'b0, out_valid}, 1);
    repeat (7) @(posedge clk);
    #1 check("ovr_set", {31'b0, overrun}, 1);
    repeat (23) @(posedge clk);
    @(negedge clk);
    read_frame(-1, 0);
    check("ovr_seq_first", {16'b0, w[0]}, 0);
    read_frame(-1, 0);
    check("ovr_seq_next", {16'b0, w[0]}, 7);

    // saturation of A_2
    gen_static = 4'b0100;
    do_reset();
    cfg_write(8'd255, 32'd70000);
    repeat (65000) @(posedge clk);
    #1 check("sat_early", {31'b0, saturated}, 0);
    @(negedge clk);
    wait_valid("sat_wait", 6000);
    read_frame(-1, 0);
    check("sat_a2", {16'b0, w[3]}, 65535);
    check("sat_a0", {16'b0, w[1]}, 0);
    check("sat_flag", {31'b0, saturated}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
